// File: rtl/mmio_bridge.sv
// mmio_bridge: stalls the pipeline while a MEM-stage load/store that falls in
// the peripheral window is carried out as a single request/ack handshake.
// Loads are lane-extracted and extended into rdata. Misaligned accesses and
// handshakes that run out of time are reported through a sticky err flag.
module mmio_bridge #(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  length,
    input  logic        sign,
    output logic        polling,
    output logic [31:0] rdata,
    output logic        periph_req,
    output logic        periph_we,
    output logic [31:0] periph_addr,
    output logic [31:0] periph_wdata,
    output logic [3:0]  periph_be,
    input  logic        periph_ack,
    input  logic [31:0] periph_rdata,
    output logic        err
);

    // The counter must be able to reach TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // A cycle without ack while the count is at CNT_LAST is the TIMEOUT-th one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic             hit;
    logic             misaligned;
    logic             accept;
    logic             fault_misalign;
    logic             req_ack;
    logic             req_timeout;
    logic [CNT_W-1:0] count_reg;

    // Access shape captured at acceptance, needed to format the load result.
    logic [1:0]       addr_lo_reg;
    logic [1:0]       length_reg;
    logic             sign_reg;

    logic [3:0]       be_fmt;
    logic [31:0]      wdata_fmt;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;
    logic [31:0]      load_ext;

    assign hit = (mem_read_en | mem_write_en) & ((addr & MMIO_MASK) == MMIO_BASE);

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    always_comb begin
        misaligned = 1'b0;
        case (length)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    // Per byte lane: enable and replicated store data for the current access.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign be_fmt[gi] = (length == 2'b00) ? (addr[1:0] == 2'(gi)) :
                                (length == 2'b01) ? (addr[1] == 1'(gi / 2)) :
                                                    1'b1;
            assign wdata_fmt[8*gi +: 8] = (length == 2'b00) ? wdata[7:0] :
                                          (length == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                                              wdata[8*gi +: 8];
        end
    endgenerate

    // Stall while a hit waits in IDLE and for the whole of REQ; never in reset.
    assign polling = ~rst & (((state_reg == IDLE) & hit) | (state_reg == REQ));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the one-cycle event strobes for the datapath.
    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        fault_misalign = 1'b0;
        req_ack        = 1'b0;
        req_timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    if (misaligned) begin
                        fault_misalign = 1'b1;
                        state_next     = DONE;
                    end else begin
                        accept     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // An ack on the final cycle wins over the timeout.
                if (periph_ack) begin
                    req_ack    = 1'b1;
                    state_next = DONE;
                end else if (count_reg == CNT_LAST) begin
                    req_timeout = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Timeout counter: cleared on acceptance, counts REQ cycles without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= '0;
        end else if ((state_reg == REQ) && !periph_ack) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Capture the access shape when the request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lo_reg <= 2'b00;
            length_reg  <= 2'b00;
            sign_reg    <= 1'b0;
        end else if (accept) begin
            addr_lo_reg <= addr[1:0];
            length_reg  <= length;
            sign_reg    <= sign;
        end
    end

    // Peripheral request bundle: loaded on acceptance, held through REQ, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periph_req   <= 1'b0;
            periph_we    <= 1'b0;
            periph_addr  <= 32'h0;
            periph_wdata <= 32'h0;
            periph_be    <= 4'h0;
        end else if (accept) begin
            periph_req   <= 1'b1;
            periph_we    <= mem_write_en;
            periph_addr  <= {addr[31:2], 2'b00};
            periph_wdata <= wdata_fmt;
            periph_be    <= be_fmt;
        end else if (req_ack || req_timeout) begin
            periph_req   <= 1'b0;
            periph_we    <= 1'b0;
            periph_addr  <= 32'h0;
            periph_wdata <= 32'h0;
            periph_be    <= 4'h0;
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_val = 8'h00;
        case (addr_lo_reg)
            2'd0:    byte_val = periph_rdata[7:0];
            2'd1:    byte_val = periph_rdata[15:8];
            2'd2:    byte_val = periph_rdata[23:16];
            default: byte_val = periph_rdata[31:24];
        endcase
        half_val = addr_lo_reg[1] ? periph_rdata[31:16] : periph_rdata[15:0];
        case (length_reg)
            2'b00:   load_ext = {{24{sign_reg & byte_val[7]}}, byte_val};
            2'b01:   load_ext = {{16{sign_reg & half_val[15]}}, half_val};
            default: load_ext = periph_rdata;
        endcase
    end

    // Load result: updated by read completions, zeroed by faults, else held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0;
        end else if (req_ack && !periph_we) begin
            rdata <= load_ext;
        end else if (req_timeout || fault_misalign) begin
            rdata <= 32'h0;
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (req_timeout || fault_misalign) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboarded bench for mmio_bridge: stimulus pushes expected peripheral
// requests and completions; a monitor pops and compares them as they appear.
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_en = 1'b0;
    logic        mem_write_en = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [1:0]  length = 2'b00;
    logic        sign = 1'b0;
    logic        polling;
    logic [31:0] rdata;
    logic        periph_req;
    logic        periph_we;
    logic [31:0] periph_addr;
    logic [31:0] periph_wdata;
    logic [3:0]  periph_be;
    logic        periph_ack = 1'b0;
    logic [31:0] periph_rdata = 32'h0;
    logic        err;

    mmio_bridge #(
        .MMIO_BASE(32'hFFFF_0000),
        .MMIO_MASK(32'hFFFF_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read_en (mem_read_en),
        .mem_write_en(mem_write_en),
        .addr        (addr),
        .wdata       (wdata),
        .length      (length),
        .sign        (sign),
        .polling     (polling),
        .rdata       (rdata),
        .periph_req  (periph_req),
        .periph_we   (periph_we),
        .periph_addr (periph_addr),
        .periph_wdata(periph_wdata),
        .periph_be   (periph_be),
        .periph_ack  (periph_ack),
        .periph_rdata(periph_rdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          poll;
    } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];

    int checks = 0;
    int errors = 0;

    // Peripheral model configuration: ack on the Nth REQ cycle (0 = never).
    int          ack_after = 0;
    logic [31:0] resp_data = 32'h0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Peripheral responder.
    initial begin
        int req_cyc = 0;
        forever begin
            @(negedge clk);
            if (periph_req && !rst) begin
                req_cyc++;
                if (req_cyc == ack_after) begin
                    periph_ack   = 1'b1;
                    periph_rdata = resp_data;
                end else begin
                    periph_ack   = 1'b0;
                    periph_rdata = 32'h0;
                end
            end else begin
                req_cyc      = 0;
                periph_ack   = 1'b0;
                periph_rdata = 32'h0;
            end
        end
    end

    // Monitor: compares requests on periph_req rise and completions on polling fall.
    initial begin
        logic req_prev  = 1'b0;
        logic poll_prev = 1'b0;
        int   poll_run  = 0;
        req_t cur;
        req_t seen;
        cpl_t c;
        cur = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                req_prev  = 1'b0;
                poll_prev = 1'b0;
                poll_run  = 0;
            end else begin
                seen = '{periph_we, periph_addr, periph_wdata, periph_be};
                if (periph_req && !req_prev) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 96'(seen), 96'h0);
                    end else begin
                        cur = req_q.pop_front();
                        chk("req_fields", 96'(seen), 96'(cur));
                    end
                end else if (periph_req) begin
                    chk("req_stable", 96'(seen), 96'(cur));
                end else begin
                    chk("idle_zero", 96'(seen), 96'h0);
                end
                req_prev = periph_req;

                if (polling) begin
                    poll_run++;
                end else if (poll_prev) begin
                    if (cpl_q.size() == 0) begin
                        chk("unexpected_cpl", 96'(poll_run), 96'h0);
                    end else begin
                        c = cpl_q.pop_front();
                        chk("cpl_rdata", 96'(rdata), 96'(c.rdata));
                        chk("cpl_err", 96'(err), 96'(c.err));
                        chk("cpl_poll_cycles", 96'(poll_run), 96'(c.poll));
                    end
                    poll_run = 0;
                end
                poll_prev = polling;
            end
        end
    end

    // Issue one MEM access (called at a negedge) and return at its DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] len, input logic sg,
                          input int ack_n, input logic [31:0] prd,
                          input logic exp_req, input logic [31:0] exp_wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_poll);
        req_t r;
        cpl_t c;
        bit   done = 1'b0;
        if (exp_req) begin
            r = '{wr, {a[31:2], 2'b00}, exp_wd, exp_be};
            req_q.push_back(r);
        end
        c.rdata = exp_rd;
        c.err   = exp_err;
        c.poll  = exp_poll;
        cpl_q.push_back(c);
        ack_after    = ack_n;
        resp_data    = prd;
        mem_read_en  = rd;
        mem_write_en = wr;
        addr         = a;
        wdata        = wd;
        length       = len;
        sign         = sg;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!polling) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk("done_wait_timeout", 96'(done), 96'h1);
        end
    endtask

    task automatic idle_inputs();
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        addr         = 32'h0;
        wdata        = 32'h0;
        length       = 2'b00;
        sign         = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, with a hit presented while reset is held.
        @(negedge clk);
        mem_read_en = 1'b1;
        addr        = 32'hFFFF_0000;
        length      = 2'b10;
        #2;
        chk("rst_polling", 96'(polling), 96'h0);
        chk("rst_req", 96'(periph_req), 96'h0);
        chk("rst_rdata", 96'(rdata), 96'h0);
        chk("rst_err", 96'(err), 96'h0);
        chk("rst_be", 96'(periph_be), 96'h0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);

        //     rd    wr    addr            wdata           len    sg    ack prdata          req   exp_wd          be       exp_rd          err   poll
        access(1'b1, 1'b0, 32'hFFFF_0004, 32'h0000_0000, 2'b10, 1'b0, 3, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0, 4);
        access(1'b1, 1'b0, 32'hFFFF_0003, 32'h0000_0000, 2'b00, 1'b1, 1, 32'h8000_0000, 1'b1, 32'h0000_0000, 4'b1000, 32'hFFFF_FF80, 1'b0, 2);
        access(1'b1, 1'b0, 32'hFFFF_0003, 32'h0000_0000, 2'b00, 1'b0, 1, 32'h8000_0000, 1'b1, 32'h0000_0000, 4'b1000, 32'h0000_0080, 1'b0, 2);
        access(1'b0, 1'b1, 32'hFFFF_0002, 32'hABCD_1234, 2'b01, 1'b0, 2, 32'hFFFF_FFFF, 1'b1, 32'h1234_1234, 4'b1100, 32'h0000_0080, 1'b0, 3);
        access(1'b1, 1'b1, 32'hFFFF_0001, 32'h0000_0055, 2'b00, 1'b0, 1, 32'h1111_1111, 1'b1, 32'h5555_5555, 4'b0010, 32'h0000_0080, 1'b0, 2);
        access(1'b1, 1'b0, 32'hFFFF_0002, 32'h0000_0000, 2'b01, 1'b1, 2, 32'h8001_7FFF, 1'b1, 32'h0000_0000, 4'b1100, 32'hFFFF_8001, 1'b0, 3);
        // Ack on the 4th REQ cycle beats the timeout.
        access(1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0000, 2'b10, 1'b0, 4, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b1111, 32'h1234_5678, 1'b0, 5);

        // Access outside the window: no stall, no request.
        mem_read_en = 1'b1;
        addr        = 32'h0000_1000;
        length      = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("nohit_polling", 96'(polling), 96'h0);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // Back-to-back hits: the second waits for DONE of the first.
        access(1'b1, 1'b0, 32'hFFFF_000C, 32'h0000_0000, 2'b10, 1'b0, 1, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 4'b1111, 32'hA5A5_A5A5, 1'b0, 2);
        access(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 2'b00, 1'b0, 1, 32'h0000_00C3, 1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00C3, 1'b0, 2);

        // No ack: four REQ cycles, then err set and held.
        access(1'b1, 1'b0, 32'hFFFF_0010, 32'h0000_0000, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1, 5);
        access(1'b0, 1'b1, 32'hFFFF_0014, 32'hCAFE_F00D, 2'b10, 1'b0, 1, 32'h0000_0000, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 1'b1, 2);

        @(negedge clk);
        pulse_reset();
        #2;
        chk("reset_clears_err", 96'(err), 96'h0);
        @(negedge clk);

        // Misaligned hits: no request, rdata zeroed, err set.
        access(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 2'b00, 1'b0, 1, 32'h0000_00C3, 1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00C3, 1'b0, 2);
        access(1'b1, 1'b0, 32'hFFFF_0001, 32'h0000_0000, 2'b10, 1'b0, 1, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1, 1);
        access(1'b0, 1'b1, 32'hFFFF_0003, 32'h0000_BEEF, 2'b01, 1'b0, 1, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1, 1);

        // Reset in the middle of REQ drops the request at once.
        req_q.push_back('{1'b0, 32'hFFFF_0020, 32'h0000_0000, 4'b1111});
        ack_after    = 0;
        mem_read_en  = 1'b1;
        mem_write_en = 1'b0;
        addr         = 32'hFFFF_0020;
        wdata        = 32'h0;
        length       = 2'b10;
        sign         = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("midreq_req_before", 96'(periph_req), 96'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("midreq_req", 96'(periph_req), 96'h0);
        chk("midreq_polling", 96'(polling), 96'h0);
        chk("midreq_err", 96'(err), 96'h0);
        chk("midreq_be", 96'(periph_be), 96'h0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // After the abort, a fresh access runs normally and nothing is replayed.
        access(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 2'b00, 1'b1, 1, 32'h0000_007F, 1'b1, 32'h0000_0000, 4'b0001, 32'h0000_007F, 1'b0, 2);
        idle_inputs();
        repeat (4) @(negedge clk);
        #3;
        chk("req_queue_drained", 96'(req_q.size()), 96'h0);
        chk("cpl_queue_drained", 96'(cpl_q.size()), 96'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter MMIO_BASE, default 32'hFFFF_0000, base address of the peripheral window.
REQ-002 Parameter MMIO_MASK, default 32'hFFFF_0000, address bits compared against MMIO_BASE.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent in REQ before abort.
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read_en  in  1  MEM-stage load.
- mem_write_en  in  1  MEM-stage store.
- addr  in  32  MEM-stage ALU result (byte address).
- wdata  in  32  store data, already forwarded.
- length  in  2  00 byte, 01 half, 10/11 word.
- sign  in  1  1 = sign-extend loads, 0 = zero-extend.
- polling  out  1  whole-pipeline stall request.
- rdata  out  32  extended load result.
- periph_req  out  1  peripheral request.
- periph_we  out  1  1 = write.
- periph_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- periph_wdata  out  32  lane-replicated store data.
- periph_be  out  4  byte enables.
- periph_ack  in  1  peripheral completion, one-cycle pulse.
- periph_rdata  in  32  read data, valid with periph_ack.
- err  out  1  sticky fault flag.

Function
REQ-005 hit = (mem_read_en | mem_write_en) & ((addr & MMIO_MASK) == MMIO_BASE); non-hit accesses are ignored entirely.
REQ-006 FSM states: IDLE, REQ, DONE.
REQ-007 IDLE: if hit, go to REQ next edge; latch addr, wdata, length, sign and we (= mem_write_en); clear timeout counter.
REQ-008 When both enables are set, the access is a write.
REQ-009 polling = (IDLE & hit) | REQ, combinational, so the stall holds the instruction from the first cycle it is in MEM.
REQ-010 polling is low in DONE; the pipeline advances on the edge that ends DONE.
REQ-011 DONE does not evaluate hit; it always returns to IDLE after exactly one cycle.
REQ-012 periph_req, periph_we, periph_addr, periph_wdata and periph_be are registered, held stable for the whole of REQ, and driven 0 outside REQ.
REQ-013 periph_be:
- byte: 4'b0001 << addr[1:0].
- half: addr[1] ? 4'b1100 : 4'b0011.
- word: 4'b1111.
REQ-014 periph_wdata:
- byte: {4{wdata[7:0]}}.
- half: {2{wdata[15:0]}}.
- word: wdata.
REQ-015 REQ: on periph_ack go to DONE; on reads, register the extracted lane (byte lane addr[1:0], half lane addr[1]) into rdata, extended per sign.
REQ-016 REQ: the counter increments each cycle without ack; on the cycle the count reaches TIMEOUT with no ack, go to DONE, set rdata = 0 and set err.
REQ-017 periph_ack in the same cycle as the timeout takes priority over the timeout, so no err is raised.
REQ-018 Misaligned hit (half with addr[0]=1, or word with addr[1:0]!=0): no periph_req is issued; IDLE goes directly to DONE; rdata = 0; err is set.
REQ-019 polling is high for the misaligned cycle in IDLE only.
REQ-020 rdata holds its value until the next completion.
REQ-021 Write completions leave rdata unchanged.
REQ-022 err is sticky until reset.
REQ-023 periph_ack seen outside REQ is ignored.
REQ-024 Transaction latency: 1 cycle (IDLE) + N cycles in REQ up to and including the ack + 1 cycle in DONE.

Reset
REQ-025 While rst is high, state = IDLE and periph_req, periph_we, periph_addr, periph_wdata, periph_be, rdata, err and the timeout counter are all 0.
REQ-026 polling is 0 in reset regardless of hit.
REQ-027 Reset asserted mid-REQ drops periph_req asynchronously, within the same cycle; the aborted transaction is not replayed.

Verification
REQ-028 Word read at 0xFFFF_0004, ack after 3 REQ cycles with periph_rdata = 0xDEAD_BEEF -> periph_be = 1111, polling high for 4 cycles, rdata = 0xDEAD_BEEF in DONE, err = 0.
REQ-029 Signed byte read at 0xFFFF_0003, periph_rdata = 0x8000_0000 -> rdata = 0xFFFF_FF80; the same read with sign = 0 -> rdata = 0x0000_0080.
REQ-030 Half write of 0x1234 at 0xFFFF_0002 -> periph_be = 1100, periph_wdata = 0x1234_1234, periph_we = 1, and rdata is unchanged after completion.
REQ-031 Read with no ack, TIMEOUT = 4 -> exactly 4 REQ cycles, then DONE with rdata = 0, err = 1 and err held; ack arriving on the 4th cycle -> err = 0.
REQ-032 Word access to 0xFFFF_0001 -> no periph_req, err = 1; access to 0x0000_1000 -> polling stays 0; back-to-back hits -> the second is accepted only after DONE.
REQ-033 rst pulsed during REQ -> periph_req = 0 immediately, state IDLE, err = 0, polling = 0.
